// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit carry chain split into STAGES chunks, one chunk per register stage.
// Optional build macro ADDER_SAT_EN saturates the sum on signed overflow.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  generate
    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The pipeline moves as one unit: it advances whenever the output slot is empty
  // or being drained, so in_ready depends only on out_valid/out_ready.
  logic adv;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  logic [STAGES-1:0] ci;
  logic [STAGES-1:0] c_n;
  logic [WIDTH-1:0]  a_n  [STAGES];
  logic [WIDTH-1:0]  b_n  [STAGES];
  logic [WIDTH-1:0]  s_n  [STAGES];
  logic [C:0]        part [STAGES];

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];

  always_comb begin
    // Stage 0 folds subtraction into the operands: a - b = a + ~b + 1.
    a_n[0] = a;
    b_n[0] = sub ? ~b : b;
    s_n[0] = '0;
    ci[0]  = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      a_n[k] = a_q[k-1];
      b_n[k] = b_q[k-1];
      s_n[k] = s_q[k-1];
      ci[k]  = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, a_n[k][k*C +: C]} + {1'b0, b_n[k][k*C +: C]} + {{C{1'b0}}, ci[k]};
      s_n[k][k*C +: C] = part[k][C-1:0];
      c_n[k] = part[k][C];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      c_q <= c_n;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        s_q[k] <= s_n[k];
      end
    end
  end

  // Overflow uses the already-inverted subtrahend held in the last stage.
  logic a_msb;
  logic b_msb;
  logic s_msb;
  assign a_msb = a_q[LAST][WIDTH-1];
  assign b_msb = b_q[LAST][WIDTH-1];
  assign s_msb = s_q[LAST][WIDTH-1];
  assign ovf   = (a_msb == b_msb) && (s_msb != a_msb);
  assign cout  = c_q[LAST];

`ifdef ADDER_SAT_EN
  assign sum = !ovf ? s_q[LAST] :
               a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum = s_q[LAST];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: table vectors, reset/backpressure sequences,
// and random streams on W=32/S=4, W=8/S=1 and W=64/S=8 instances.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance W=32, S=4
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;
  // Extra instances for parameter coverage
  logic        e8_in_valid, e8_in_ready, e8_cin, e8_sub, e8_out_valid, e8_out_ready, e8_cout, e8_ovf;
  logic [7:0]  e8_a, e8_b, e8_sum;
  logic        e64_in_valid, e64_in_ready, e64_cin, e64_sub, e64_out_valid, e64_out_ready, e64_cout, e64_ovf;
  logic [63:0] e64_a, e64_b, e64_sum;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(e8_in_valid), .in_ready(e8_in_ready), .a(e8_a), .b(e8_b),
    .cin(e8_cin), .sub(e8_sub), .out_valid(e8_out_valid), .out_ready(e8_out_ready), .sum(e8_sum),
    .cout(e8_cout), .ovf(e8_ovf));

  pipelined_adder #(.WIDTH(64), .STAGES(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(e64_in_valid), .in_ready(e64_in_ready), .a(e64_a), .b(e64_b),
    .cin(e64_cin), .sub(e64_sub), .out_valid(e64_out_valid), .out_ready(e64_out_ready), .sum(e64_sum),
    .cout(e64_cout), .ovf(e64_ovf));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  logic lat_en = 1'b0;

  // Expected results packed as {ovf, cout, sum zero-extended to 64 bits}
  logic [65:0] exp_q[$];
  logic [65:0] e8_q[$];
  logic [65:0] e64_q[$];
  int          stamp_q[$];
  logic [65:0] cur_exp, e8_exp, e64_exp;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  vec_t vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: exact signed arithmetic decides overflow, unsigned sum gives carry.
  function automatic logic [65:0] model(input int w, input logic [63:0] ia, input logic [63:0] ib,
                                        input logic icin, input logic isub);
    logic [63:0] mask, am, bm, bx, s;
    logic [64:0] full;
    logic signed [66:0] sa, sb, ex, lim;
    logic c0, co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = ia & mask;
    bm   = ib & mask;
    bx   = isub ? (~ib & mask) : bm;
    c0   = isub ? 1'b1 : icin;
    full = {1'b0, am} + {1'b0, bx} + {64'd0, c0};
    co   = full[w];
    s    = full[63:0] & mask;
    sa   = am[w-1] ? $signed({3'b111, am | ~mask}) : $signed({3'b000, am});
    sb   = bm[w-1] ? $signed({3'b111, bm | ~mask}) : $signed({3'b000, bm});
    ex   = isub ? (sa - sb) : (sa + sb + $signed({66'd0, c0}));
    lim  = 67'sd1 <<< (w - 1);
    ov   = (ex >= lim) || (ex < -lim);
`ifdef ADDER_SAT_EN
    if (ov) s = am[w-1] ? (64'd1 << (w - 1)) : (mask >> 1);
`endif
    return {ov, co, s};
  endfunction

  function automatic logic [63:0] rand_val(input int w);
    logic [63:0] mask, r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = 64'd1 << (w - 1);
      3: r = mask >> 1;
      default: r = {$urandom(), $urandom()};
    endcase
    return r & mask;
  endfunction

  // Scoreboards: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("dut32_unexpected_output", {ovf, cout, 32'd0, sum}, 66'h3_FFFF_FFFF_FFFF_FFFF);
        end else begin
          check("dut32_result", {ovf, cout, 32'd0, sum}, exp_q.pop_front());
          if (lat_en) check("dut32_latency", 66'(cyc - stamp_q[0]), 66'd4);
          void'(stamp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        in_cnt++;
        exp_q.push_back(cur_exp);
        stamp_q.push_back(cyc);
      end
      if (e8_out_valid && e8_out_ready) begin
        if (e8_q.size() == 0) check("dut8_unexpected_output", {e8_ovf, e8_cout, 56'd0, e8_sum}, '1);
        else check("dut8_result", {e8_ovf, e8_cout, 56'd0, e8_sum}, e8_q.pop_front());
      end
      if (e8_in_valid && e8_in_ready) e8_q.push_back(e8_exp);
      if (e64_out_valid && e64_out_ready) begin
        if (e64_q.size() == 0) check("dut64_unexpected_output", {e64_ovf, e64_cout, e64_sum}, '1);
        else check("dut64_result", {e64_ovf, e64_cout, e64_sum}, e64_q.pop_front());
      end
      if (e64_in_valid && e64_in_ready) e64_q.push_back(e64_exp);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the op.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                      input logic ts, input logic [65:0] te);
    int n;
    n = 0;
    in_valid = 1'b1; a = ta; b = tb2; cin = tc; sub = ts; cur_exp = te;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_accept_timeout", 66'd0, 66'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] ra, rb;
    logic rc, rs;
    ra = rand_val(32); rb = rand_val(32);
    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    send(ra, rb, rc, rs, model(32, {32'd0, ra}, {32'd0, rb}, rc, rs));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || e8_q.size() != 0 || e64_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 66'(exp_q.size() + e8_q.size() + e64_q.size()), 66'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, acc0;
    logic [65:0] snap;
    logic snap_ok;

    vecs[0]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
`ifdef ADDER_SAT_EN
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
    vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
`else
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
`endif
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0};
    vecs[10] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    // Clock/reset
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1; cur_exp = '0;
    e8_in_valid = 1'b0; e8_a = '0; e8_b = '0; e8_cin = 1'b0; e8_sub = 1'b0; e8_out_ready = 1'b1; e8_exp = '0;
    e64_in_valid = 1'b0; e64_a = '0; e64_b = '0; e64_cin = 1'b0; e64_sub = 1'b0; e64_out_ready = 1'b1; e64_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 66'(out_valid), 66'd0);
    check("reset_outputs", {ovf, cout, 32'd0, sum}, 66'd0);
    check("reset_in_ready", 66'(in_ready), 66'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while three ops are in flight
    out_ready = 1'b0;
    repeat (3) send_rand();
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_pre_out_valid", 66'(out_valid), 66'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", 66'(out_valid), 66'd0);
    check("rst_async_outputs", {ovf, cout, 32'd0, sum}, 66'd0);
    exp_q.delete();
    stamp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    base = out_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("rst_flush_no_output", 66'(out_cnt - base), 66'd0);

    // Table vectors streamed back to back; latency checked per op
    lat_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           {vecs[i].ov, vecs[i].co, 32'd0, vecs[i].s});
    end
    wait_drain("table_drain");
    lat_en = 1'b0;

    // Backpressure: consumer stalls for 6 cycles while the producer keeps offering
    out_ready = 1'b0;
    acc0 = in_cnt;
    snap = '0;
    snap_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      a = rand_val(32); b = rand_val(32);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      cur_exp = model(32, {32'd0, a}, {32'd0, b}, cin, sub);
      @(negedge clk);
      if (out_valid) begin
        check("bp_in_ready_low", 66'(in_ready), 66'd0);
        if (snap_ok) check("bp_output_stable", {ovf, cout, 32'd0, sum}, snap);
        snap = {ovf, cout, 32'd0, sum};
        snap_ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_buffered_ops", 66'(in_cnt - acc0), 66'd4);
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Random streams on all three instances with random valid/ready
    for (int i = 0; i < 13000; i++) begin
      in_valid = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 8);
      a = rand_val(32); b = rand_val(32);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      cur_exp = model(32, {32'd0, a}, {32'd0, b}, cin, sub);
      e8_in_valid = ($urandom_range(0, 9) < 9);
      e8_out_ready = ($urandom_range(0, 9) < 9);
      e8_a = 8'(rand_val(8)); e8_b = 8'(rand_val(8));
      e8_cin = 1'($urandom_range(0, 1)); e8_sub = 1'($urandom_range(0, 1));
      e8_exp = model(8, {56'd0, e8_a}, {56'd0, e8_b}, e8_cin, e8_sub);
      e64_in_valid = ($urandom_range(0, 9) < 9);
      e64_out_ready = ($urandom_range(0, 9) < 9);
      e64_a = rand_val(64); e64_b = rand_val(64);
      e64_cin = 1'($urandom_range(0, 1)); e64_sub = 1'($urandom_range(0, 1));
      e64_exp = model(64, e64_a, e64_b, e64_cin, e64_sub);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; e8_in_valid = 1'b0; e64_in_valid = 1'b0;
    out_ready = 1'b1; e8_out_ready = 1'b1; e64_out_ready = 1'b1;
    wait_drain("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
